// File: rtl/reg_bus_sequencer.sv
// -----------------------------------------------------------------------------
// reg_bus_sequencer
//
// Sequences register-to-register transfers on the shared 16-bit internal bus
// for a bank of NREGS register pairs (high byte / low byte).
//
// Each accepted request produces a source "out" strobe for one cycle (C1),
// followed by a destination "in" strobe plus done for one cycle (C2). A new
// request's out strobe overlaps the previous request's in strobe, so the
// sustained rate is one transfer per clock.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   req_valid / req_ready    request handshake (req_ready is combinational)
//   req_src, req_dst         register pair indices
//   req_word                 1: 16-bit transfer, 0: byte transfer
//   req_src_hi, req_dst_hi   byte selects for source / destination
//   req_imm_src, req_imm     immediate source, driven by this block
//   cs_{h,l,16}_out          one-hot source drive strobes (C1)
//   cs_{h,l,16}_in           one-hot destination load strobes (C2)
//   imm_drive, imm_bus       immediate bus drive (C2), imm_bus=0 when idle
//   done                     destination strobe active this cycle
//   err                      accepted request had an out-of-range index (C1)
// -----------------------------------------------------------------------------
module reg_bus_sequencer #(
    parameter int NREGS = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_src,
    input  logic [IDX_W-1:0] req_dst,
    input  logic             req_word,
    input  logic             req_src_hi,
    input  logic             req_dst_hi,
    input  logic             req_imm_src,
    input  logic [15:0]      req_imm,
    output logic [NREGS-1:0] cs_h_out,
    output logic [NREGS-1:0] cs_l_out,
    output logic [NREGS-1:0] cs_16_out,
    output logic [NREGS-1:0] cs_h_in,
    output logic [NREGS-1:0] cs_l_in,
    output logic [NREGS-1:0] cs_16_in,
    output logic             imm_drive,
    output logic [15:0]      imm_bus,
    output logic             done,
    output logic             err
);

    // One extra bit so NREGS == 2**IDX_W is representable.
    localparam logic [IDX_W:0] NREGS_LIM = (IDX_W + 1)'(NREGS);

    // Stage 1 holds the transfer whose source strobe is currently active.
    // Invalid requests never enter it, so s1_valid_reg implies in-range indices.
    logic             s1_valid_reg;
    logic [IDX_W-1:0] s1_dst_reg;
    logic             s1_word_reg;
    logic             s1_dst_hi_reg;
    logic             s1_imm_src_reg;
    logic [15:0]      s1_imm_reg;

    // Stage 2 is represented directly by the registered destination outputs.
    logic [NREGS-1:0] cs_h_out_reg,  cs_h_out_next;
    logic [NREGS-1:0] cs_l_out_reg,  cs_l_out_next;
    logic [NREGS-1:0] cs_16_out_reg, cs_16_out_next;
    logic [NREGS-1:0] cs_h_in_reg,   cs_h_in_next;
    logic [NREGS-1:0] cs_l_in_reg,   cs_l_in_next;
    logic [NREGS-1:0] cs_16_in_reg,  cs_16_in_next;
    logic             imm_drive_reg, imm_drive_next;
    logic [15:0]      imm_bus_reg,   imm_bus_next;
    logic             done_reg,      done_next;
    logic             err_reg,       err_next;

    logic [NREGS-1:0] src_sel;
    logic [NREGS-1:0] dst_sel;
    logic             req_bad;
    logic             hazard;
    logic             accept;
    logic             issue;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_dec
            assign src_sel[gi] = (req_src == IDX_W'(gi));
            assign dst_sel[gi] = (s1_dst_reg == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        // The source index is meaningless for immediate transfers.
        req_bad = ({1'b0, req_dst} >= NREGS_LIM) ||
                  (!req_imm_src && ({1'b0, req_src} >= NREGS_LIM));

        // Stage 1 writes at the same edge the new request would read its
        // source, so any byte overlap must wait one cycle. Stage 2 writes a
        // cycle earlier and never conflicts.
        hazard = s1_valid_reg && !req_imm_src && (req_src == s1_dst_reg) &&
                 (req_word || s1_word_reg || (req_src_hi == s1_dst_hi_reg));

        req_ready = !hazard;
        accept    = req_valid && req_ready;
        issue     = accept && !req_bad;

        cs_16_out_next = (issue && !req_imm_src && req_word) ? src_sel : '0;
        cs_h_out_next  = (issue && !req_imm_src && !req_word && req_src_hi) ? src_sel : '0;
        cs_l_out_next  = (issue && !req_imm_src && !req_word && !req_src_hi) ? src_sel : '0;
        err_next       = accept && req_bad;

        cs_16_in_next  = (s1_valid_reg && s1_word_reg) ? dst_sel : '0;
        cs_h_in_next   = (s1_valid_reg && !s1_word_reg && s1_dst_hi_reg) ? dst_sel : '0;
        cs_l_in_next   = (s1_valid_reg && !s1_word_reg && !s1_dst_hi_reg) ? dst_sel : '0;
        done_next      = s1_valid_reg;
        imm_drive_next = s1_valid_reg && s1_imm_src_reg;
        imm_bus_next   = 16'h0000;
        if (imm_drive_next) begin
            imm_bus_next = s1_word_reg ? s1_imm_reg : {8'h00, s1_imm_reg[7:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            s1_dst_reg     <= '0;
            s1_word_reg    <= 1'b0;
            s1_dst_hi_reg  <= 1'b0;
            s1_imm_src_reg <= 1'b0;
            s1_imm_reg     <= 16'h0000;
            cs_h_out_reg   <= '0;
            cs_l_out_reg   <= '0;
            cs_16_out_reg  <= '0;
            cs_h_in_reg    <= '0;
            cs_l_in_reg    <= '0;
            cs_16_in_reg   <= '0;
            imm_drive_reg  <= 1'b0;
            imm_bus_reg    <= 16'h0000;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            s1_valid_reg <= issue;
            if (issue) begin
                s1_dst_reg     <= req_dst;
                s1_word_reg    <= req_word;
                s1_dst_hi_reg  <= req_dst_hi;
                s1_imm_src_reg <= req_imm_src;
                s1_imm_reg     <= req_imm;
            end
            cs_h_out_reg  <= cs_h_out_next;
            cs_l_out_reg  <= cs_l_out_next;
            cs_16_out_reg <= cs_16_out_next;
            cs_h_in_reg   <= cs_h_in_next;
            cs_l_in_reg   <= cs_l_in_next;
            cs_16_in_reg  <= cs_16_in_next;
            imm_drive_reg <= imm_drive_next;
            imm_bus_reg   <= imm_bus_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    assign cs_h_out  = cs_h_out_reg;
    assign cs_l_out  = cs_l_out_reg;
    assign cs_16_out = cs_16_out_reg;
    assign cs_h_in   = cs_h_in_reg;
    assign cs_l_in   = cs_l_in_reg;
    assign cs_16_in  = cs_16_in_reg;
    assign imm_drive = imm_drive_reg;
    assign imm_bus   = imm_bus_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule
